// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
//
// Sends one DATA_BITS word per frame: a start bit (0), the data LSB first, an
// optional parity bit, then STOP_BITS stop bits (1). Bit timing comes from an
// internal baud counter running on clk, so there is no derived clock.
//
// Optional feature: define UART_TX_PARITY_EN to add the par_odd input and a
// parity bit after the data. The parity bit is ^data ^ par_odd, so par_odd=1
// gives odd parity.
//
// Parameters:
//   CLK_DIV    clocks per bit (>= 2)
//   DATA_BITS  data bits per frame (5..9)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   clk      system clock; all logic is on posedge
//   rst_l    asynchronous, active-low reset
//   start    frame request; accepted when start && ready
//   d_in     word to send; sampled only on the accept cycle
//   par_odd  parity sense, sampled with d_in (UART_TX_PARITY_EN only)
//   ready    idle; a word can be accepted this cycle
//   busy     frame in progress (~ready)
//   done     one-cycle pulse after the last stop bit completes
//   tx       serial line, idle high
module uart_tx_param #(
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] d_in,
`ifdef UART_TX_PARITY_EN
    input  logic                 par_odd,
`endif
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int unsigned      BaudW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLK_DIV - 1);
    localparam logic [3:0]       DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]       StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [BaudW-1:0]     baud_q, baud_d;
    // Counts data bits in StData and stop bits in StStop.
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 done_q, done_d;
    logic                 baud_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign baud_tick = (baud_q == BaudLast);

    // State register and datapath flops.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStart;
                    baud_d  = '0;
                    bit_d   = '0;
                    shreg_d = d_in;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^d_in) ^ par_odd;
`endif
                end
            end
            StStart: begin
                if (baud_tick) begin
                    state_d = StData;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DataLast) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    state_d = StStop;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
`endif
            StStop: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (bit_q == StopLast) begin
                        // done is registered so it coincides with ready in StIdle.
                        state_d = StIdle;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                // Illegal encoding: drop whatever was in flight.
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b1;
        tx    = 1'b1;
        done  = done_q;
        case (state_q)
            StIdle: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            StStart: tx = 1'b0;
            StData:  tx = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx = par_q;
`endif
            StStop:  tx = 1'b1;
            default: tx = 1'b1;
        endcase
    end

endmodule
